// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

endpackage

// File: rtl/if_buf.sv
// Single-entry holding register for an IF output that ID could not take yet.
module if_buf
  import if_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] d_pc,
  input  logic [31:0] d_inst,
  input  logic        d_adel,
  output logic [31:0] q_pc,
  output logic [31:0] q_inst,
  output logic        q_adel
);

  // Clear wins over load so a flush never leaves a stale entry behind.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q_pc   <= 32'd0;
      q_inst <= 32'd0;
      q_adel <= 1'b0;
    end else if (clear) begin
      q_pc   <= 32'd0;
      q_inst <= 32'd0;
      q_adel <= 1'b0;
    end else if (load) begin
      q_pc   <= d_pc;
      q_inst <= d_inst;
      q_adel <= d_adel;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// MIPS instruction-fetch stage: PC generation, single-outstanding SRAM-like
// instruction port, branch delay slot and exception redirect handling.
module if_fetch
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        if_id_stall,
  input  logic        exc_oc,
  input  logic [31:0] exc_pc,
  input  logic        id_br_taken,
  input  logic [31:0] id_br_target,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_adel,
  output state_t      dbg_state
);

  // Handshakes: a request transfers on a cycle with inst_req && inst_addr_ok;
  // once raised, inst_req/inst_addr hold until that cycle. Read data is taken
  // on any inst_data_ok cycle while waiting. The IF output transfers to ID on
  // a cycle with if_valid && !if_id_stall; otherwise it is held unchanged.

  state_t      state, state_d;
  logic [31:0] fetch_pc, fetch_pc_d;
  logic        redir_valid, redir_valid_d;
  logic [31:0] redir_pc, redir_pc_d;
  logic        br_pend, br_pend_d;
  logic [31:0] br_pc, br_pc_d;
  logic        cancel, cancel_d;

  logic        buf_load, buf_clear;
  logic [31:0] buf_d_pc, buf_d_inst;
  logic        buf_d_adel;
  logic [31:0] buf_pc, buf_inst;
  logic        buf_adel;

  logic        misaligned;
  logic        br_now;
  logic        consume;

  assign misaligned = |fetch_pc[1:0];
  assign br_now     = id_br_taken && !if_id_stall;
  assign inst_addr  = fetch_pc;
  assign dbg_state  = state;

  if_buf u_buf (
    .clk    (clk),
    .resetn (resetn),
    .load   (buf_load),
    .clear  (buf_clear),
    .d_pc   (buf_d_pc),
    .d_inst (buf_d_inst),
    .d_adel (buf_d_adel),
    .q_pc   (buf_pc),
    .q_inst (buf_inst),
    .q_adel (buf_adel)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_REQ;
      fetch_pc    <= RESET_PC;
      redir_valid <= 1'b0;
      redir_pc    <= 32'd0;
      br_pend     <= 1'b0;
      br_pc       <= 32'd0;
      cancel      <= 1'b0;
    end else begin
      state       <= state_d;
      fetch_pc    <= fetch_pc_d;
      redir_valid <= redir_valid_d;
      redir_pc    <= redir_pc_d;
      br_pend     <= br_pend_d;
      br_pc       <= br_pc_d;
      cancel      <= cancel_d;
    end
  end

  always_comb begin
    state_d       = state;
    fetch_pc_d    = fetch_pc;
    redir_valid_d = redir_valid;
    redir_pc_d    = redir_pc;
    br_pend_d     = br_pend;
    br_pc_d       = br_pc;
    cancel_d      = cancel;
    buf_load      = 1'b0;
    buf_clear     = 1'b0;
    buf_d_pc      = fetch_pc;
    buf_d_inst    = inst_rdata;
    buf_d_adel    = 1'b0;
    consume       = 1'b0;
    inst_req      = 1'b0;
    if_valid      = 1'b0;
    if_pc         = buf_pc;
    if_inst       = buf_inst;
    if_adel       = buf_adel;

    case (state)
      S_REQ: begin
        if (misaligned) begin
          // Address error is reported in place; the PC stays put until a flush.
          if_valid = !exc_oc;
          if_pc    = fetch_pc;
          if_inst  = 32'd0;
          if_adel  = 1'b1;
          if (exc_oc) begin
            fetch_pc_d = exc_pc;
          end else if (if_id_stall) begin
            buf_load   = 1'b1;
            buf_d_inst = 32'd0;
            buf_d_adel = 1'b1;
            state_d    = S_HOLD;
          end
        end else begin
          inst_req = 1'b1;
          if (inst_addr_ok) begin
            state_d       = S_WAIT;
            cancel_d      = redir_valid || exc_oc;
            redir_valid_d = 1'b0;
          end else if (exc_oc) begin
            redir_valid_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          if (cancel || exc_oc) begin
            state_d    = S_REQ;
            cancel_d   = 1'b0;
            fetch_pc_d = exc_oc ? exc_pc : redir_pc;
          end else begin
            if_valid = 1'b1;
            if_pc    = fetch_pc;
            if_inst  = inst_rdata;
            if_adel  = 1'b0;
            state_d  = if_id_stall ? S_HOLD : S_REQ;
            buf_load = if_id_stall;
            consume  = !if_id_stall;
          end
        end else if (exc_oc) begin
          cancel_d = 1'b1;
        end
      end
      S_HOLD: begin
        if_valid = !exc_oc;
        if (exc_oc) begin
          state_d    = S_REQ;
          fetch_pc_d = exc_pc;
        end else if (!if_id_stall) begin
          state_d = S_REQ;
          consume = 1'b1;
        end
      end
      default: state_d = S_REQ;
    endcase

    // The instruction leaving IF is the delay slot of any branch in ID.
    if (exc_oc) begin
      redir_pc_d = exc_pc;
      br_pend_d  = 1'b0;
      buf_clear  = 1'b1;
    end else if (consume) begin
      fetch_pc_d = br_now  ? id_br_target :
                   br_pend ? br_pc : fetch_pc + 32'd4;
      br_pend_d  = 1'b0;
    end else if (br_now) begin
      br_pend_d = 1'b1;
      br_pc_d   = id_br_target;
    end
  end

endmodule
